// File: rtl/prf_free_list.sv
// ============================================================================
//  Module   : prf_free_list
//  Purpose  : Physical-register free list. A circular buffer that hands out new
//             pdests on rename, takes back old mappings on retire, and rewinds
//             speculative allocations on flush.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prf_free_list #(
    parameter int SCALAR  = 2,
    parameter int PRF_IDX = 6,
    parameter int FL_SZ   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [SCALAR-1:0]           alloc_req,
    output logic [SCALAR*PRF_IDX-1:0]   alloc_pidx,
    output logic                        alloc_ok,
    input  logic [SCALAR-1:0]           retire,
    input  logic [SCALAR*PRF_IDX-1:0]   retire_old_pidx,
    output logic [PRF_IDX-1:0]          free_cnt
);

    localparam int c_AW   = $clog2(FL_SZ);
    localparam int c_PW   = c_AW + 1;
    localparam int c_BASE = (1 << PRF_IDX) - FL_SZ;
    localparam logic [c_PW:0] c_CAP = (c_PW+1)'(FL_SZ);

    logic [PRF_IDX-1:0] r_mem [FL_SZ];
    logic [c_PW-1:0]    r_head;
    logic [c_PW-1:0]    r_tail;
    logic [c_PW-1:0]    r_rhead;

    logic [c_PW-1:0]    w_cnt;
    logic [c_PW-1:0]    w_req_cnt;
    logic [c_PW-1:0]    w_grant_off;
    logic [c_PW-1:0]    w_rd_ptr;
    logic               w_alloc_ok;
    logic [c_PW-1:0]    w_push_cnt;
    logic [c_PW-1:0]    w_rhead_nxt;
    logic               w_wr_en  [SCALAR];
    logic [c_PW-1:0]    w_wr_ptr [SCALAR];
    logic               w_overflow;

    // Wrap bit makes tail - head distinguish full (FL_SZ) from empty (0).
    assign w_cnt    = r_tail - r_head;
    assign free_cnt = PRF_IDX'(w_cnt);
    assign alloc_ok = w_alloc_ok;

    always_comb begin
        w_req_cnt = '0;
        for (int w = 0; w < SCALAR; w++) begin
            w_req_cnt = w_req_cnt + c_PW'(alloc_req[w]);
        end
        w_alloc_ok = !reset && !flush && (w_req_cnt <= w_cnt);

        // Requested ways take consecutive entries from head in way order.
        alloc_pidx  = '0;
        w_grant_off = '0;
        w_rd_ptr    = '0;
        for (int w = 0; w < SCALAR; w++) begin
            if (alloc_req[w] && w_alloc_ok) begin
                w_rd_ptr = r_head + w_grant_off;
                alloc_pidx[w*PRF_IDX +: PRF_IDX] = r_mem[w_rd_ptr[c_AW-1:0]];
                w_grant_off = w_grant_off + 1'b1;
            end
        end
    end

    always_comb begin
        w_push_cnt = '0;
        w_overflow = 1'b0;
        for (int w = 0; w < SCALAR; w++) begin
            w_wr_en[w]  = 1'b0;
            w_wr_ptr[w] = r_tail + w_push_cnt;
            // The zero register is never returned to the list.
            if (retire[w] && (retire_old_pidx[w*PRF_IDX +: PRF_IDX] != '0)) begin
                if (({1'b0, w_cnt} + {1'b0, w_push_cnt}) < c_CAP) begin
                    w_wr_en[w] = 1'b1;
                    w_push_cnt = w_push_cnt + 1'b1;
                end else begin
                    w_overflow = 1'b1;
                end
            end
        end
        w_rhead_nxt = r_rhead + w_push_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FL_SZ; i++) begin
                r_mem[i] <= PRF_IDX'(c_BASE + i);
            end
            r_head  <= '0;
            r_rhead <= '0;
            r_tail  <= c_PW'(FL_SZ);
        end else begin
            for (int w = 0; w < SCALAR; w++) begin
                if (w_wr_en[w]) begin
                    r_mem[w_wr_ptr[w][c_AW-1:0]] <= retire_old_pidx[w*PRF_IDX +: PRF_IDX];
                end
            end
            r_tail  <= r_tail + w_push_cnt;
            r_rhead <= w_rhead_nxt;
            if (flush) begin
                r_head <= w_rhead_nxt;
            end else if (w_alloc_ok) begin
                r_head <= r_head + w_req_cnt;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!w_overflow)
                else $error("prf_free_list: retire exceeds list capacity, write dropped");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_prf_free_list.sv
// Bench for prf_free_list: queue-based reference model, scoreboard and monitor.
`default_nettype none

module tb_prf_free_list;

    localparam int SC = 2;
    localparam int PI = 6;
    localparam int FL = 32;

    typedef logic [PI-1:0] idx_t;
    typedef struct packed {
        logic              ok;
        logic [SC*PI-1:0]  pidx;
        logic [PI-1:0]     cnt;
        logic              chk_cnt;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               flush = 1'b0;
    logic [SC-1:0]      alloc_req = '0;
    logic [SC*PI-1:0]   alloc_pidx;
    logic               alloc_ok;
    logic [SC-1:0]      retire = '0;
    logic [SC*PI-1:0]   retire_old_pidx = '0;
    logic [PI-1:0]      free_cnt;

    prf_free_list #(.SCALAR(SC), .PRF_IDX(PI), .FL_SZ(FL)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .alloc_req       (alloc_req),
        .alloc_pidx      (alloc_pidx),
        .alloc_ok        (alloc_ok),
        .retire          (retire),
        .retire_old_pidx (retire_old_pidx),
        .free_cnt        (free_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: free entries in allocation order, speculatively
    // allocated entries (rewound on flush), and architecturally mapped regs.
    idx_t q_free[$];
    idx_t q_spec[$];
    idx_t pool[$];
    exp_t sb[$];
    bit   model_valid = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic model_reset();
        q_free.delete();
        q_spec.delete();
        pool.delete();
        for (int i = 0; i < FL; i++) q_free.push_back(idx_t'(64 - FL + i));
        for (int i = 1; i < 64 - FL; i++) pool.push_back(idx_t'(i));
        model_valid = 1'b1;
    endtask

    task automatic step(input logic rst, input logic fl, input logic [SC-1:0] areq,
                        input logic [SC-1:0] ret, input idx_t o0, input idx_t o1);
        exp_t e;
        int   n, k, acc, cnt0;
        idx_t olds[SC];
        @(posedge clk);
        #1;
        n = $countones(areq);
        e.chk_cnt = model_valid;
        e.cnt     = PI'(q_free.size());
        e.ok      = !rst && !fl && (n <= q_free.size());
        e.pidx    = '0;
        k = 0;
        for (int w = 0; w < SC; w++) begin
            if (areq[w] && e.ok) begin
                e.pidx[w*PI +: PI] = q_free[k];
                k++;
            end
        end
        sb.push_back(e);

        reset           = rst;
        flush           = fl;
        alloc_req       = areq;
        retire          = ret;
        retire_old_pidx = {o1, o0};

        if (rst) begin
            model_reset();
        end else begin
            olds[0] = o0;
            olds[1] = o1;
            cnt0 = q_free.size();
            acc  = 0;
            if (e.ok) for (int j = 0; j < k; j++) q_spec.push_back(q_free.pop_front());
            for (int w = 0; w < SC; w++) begin
                if (ret[w] && olds[w] != 0 && (cnt0 + acc) < FL) begin
                    q_free.push_back(olds[w]);
                    acc++;
                    if (q_spec.size() > 0) pool.push_back(q_spec.pop_front());
                end
            end
            if (fl) begin
                q_free = {q_spec, q_free};
                q_spec.delete();
            end
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
    endtask

    task automatic random_cycle();
        logic rst, fl;
        logic [SC-1:0] areq, ret;
        idx_t o[SC];
        int nr, lim;
        rst  = ($urandom_range(0, 99) == 0);
        fl   = ($urandom_range(0, 15) == 0);
        areq = SC'($urandom);
        lim  = (q_spec.size() < pool.size()) ? q_spec.size() : pool.size();
        nr   = $urandom_range(0, 2);
        if (nr > lim) nr = lim;
        ret = '0;
        if (nr == 2) ret = 2'b11;
        else if (nr == 1) ret = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        for (int w = 0; w < SC; w++) begin
            o[w] = idx_t'($urandom_range(1, 63));
            if (ret[w]) begin
                if ($urandom_range(0, 9) == 0) begin
                    o[w] = '0;
                end else begin
                    int p;
                    p = $urandom_range(0, pool.size() - 1);
                    o[w] = pool[p];
                    pool.delete(p);
                end
            end
        end
        step(rst, fl, areq, ret, o[0], o[1]);
    endtask

    // Monitor: the DUT presents alloc_ok/alloc_pidx/free_cnt every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (alloc_ok !== e.ok) begin
                    errors++;
                    $display("FAIL alloc_ok t=%0t got=%0b exp=%0b", $time, alloc_ok, e.ok);
                end
                checks++;
                if (alloc_pidx !== e.pidx) begin
                    errors++;
                    $display("FAIL alloc_pidx t=%0t got=%0d,%0d exp=%0d,%0d", $time,
                             alloc_pidx[11:6], alloc_pidx[5:0], e.pidx[11:6], e.pidx[5:0]);
                end
                if (e.chk_cnt) begin
                    checks++;
                    if (free_cnt !== e.cnt) begin
                        errors++;
                        $display("FAIL free_cnt t=%0t got=%0d exp=%0d", $time, free_cnt, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout scoreboard_pending=%0d", sb.size());
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset with all inputs active: outputs must stay quiet.
        step(1'b1, 1'b0, 2'b11, 2'b11, 6'd7, 6'd8);
        step(1'b1, 1'b1, 2'b11, 2'b00, 6'd0, 6'd0);
        // Dual allocation from reset.
        step(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
        idle(1);
        // Way1-only request, then both.
        step(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
        step(1'b0, 1'b0, 2'b10, 2'b00, 6'd0, 6'd0);
        step(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
        idle(1);
        // Drain to empty, stall, free one entry, grant it next cycle.
        step(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
        step(1'b0, 1'b0, 2'b01, 2'b01, 6'd5, 6'd0);
        step(1'b0, 1'b0, 2'b01, 2'b00, 6'd0, 6'd0);
        idle(1);
        // Allocate 6, retire 2, flush, then walk through the wrap.
        step(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
        step(1'b0, 1'b0, 2'b00, 2'b11, 6'd3, 6'd4);
        step(1'b0, 1'b1, 2'b00, 2'b00, 6'd0, 6'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
        idle(1);
        // Flush with simultaneous alloc and retire.
        step(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
        step(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
        step(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
        step(1'b0, 1'b1, 2'b11, 2'b11, 6'd9, 6'd10);
        step(1'b0, 1'b0, 2'b11, 2'b00, 6'd0, 6'd0);
        // Zero-register retire is ignored.
        step(1'b0, 1'b0, 2'b00, 2'b01, 6'd0, 6'd0);
        step(1'b0, 1'b0, 2'b00, 2'b11, 6'd0, 6'd12);
        idle(1);
        // Mid-operation reset overrides everything else.
        step(1'b1, 1'b1, 2'b11, 2'b11, 6'd5, 6'd6);
        idle(1);
        // Randomized traffic.
        step(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
        for (int i = 0; i < 500; i++) random_cycle();
        idle(2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
